// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoding digits
// and the iteration-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    OUT_LO,
    OUT_HI
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } digit_t;

  // Two multiplier bits per cycle over the W+2-bit extended multiplier.
  function automatic int iter_count(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Combinational radix-4 Booth recoder: maps {q1, q0, q-1} to a digit and
// produces the matching signed addend at accumulator width.
module booth_r4_recode
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   i_window,
  input  logic [W+1:0] i_m,
  output logic [W+3:0] o_addend
);

  digit_t       w_digit;
  logic [W+3:0] w_m1;
  logic [W+3:0] w_m2;

  assign w_m1 = {{2{i_m[W+1]}}, i_m};
  assign w_m2 = {w_m1[W+2:0], 1'b0};

  always_comb begin
    w_digit = ZERO;
    case (i_window)
      3'b001, 3'b010: w_digit = PM;
      3'b011:         w_digit = P2M;
      3'b100:         w_digit = N2M;
      3'b101, 3'b110: w_digit = NM;
      default:        w_digit = ZERO;
    endcase
  end

  always_comb begin
    o_addend = '0;
    case (w_digit)
      PM:      o_addend = w_m1;
      P2M:     o_addend = w_m2;
      NM:      o_addend = -w_m1;
      N2M:     o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/boothr4_mul.sv
// Parametrised radix-4 Booth multiplier (signed/unsigned) behind a start/busy
// handshake; the 2W-bit product is held and streamed low word first.
module boothr4_mul
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   M,
  input  logic [W-1:0]   Q,
  output logic           busy,
  output logic           out_valid,
  output logic           out_hi,
  output logic [W-1:0]   outbus,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int N  = iter_count(W);
  localparam int CW = $clog2(N + 1);
  localparam int TW = 2 * W + 7;

  if ((W % 2) != 0 || W < 4) begin : g_bad_width
    $error("boothr4_mul: W must be even and at least 4");
  end

  state_t         r_state;
  state_t         w_next;
  logic [W+3:0]   r_a;
  logic [W+1:0]   r_q;
  logic [W+1:0]   r_m;
  logic           r_qm1;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_out_valid;
  logic           r_out_hi;
  logic           r_done;
  logic [W-1:0]   r_outbus;
  logic [2*W-1:0] r_product;

  logic [W+3:0]   w_addend;
  logic [W+3:0]   w_sum;
  logic [TW-1:0]  w_shift;
  logic           w_last;
  logic [W+1:0]   w_m_ext;
  logic [W+1:0]   w_q_ext;

  booth_r4_recode #(.W(W)) u_recode (
    .i_window ({r_q[1:0], r_qm1}),
    .i_m      (r_m),
    .o_addend (w_addend)
  );

  assign w_sum   = r_a + w_addend;
  assign w_shift = $signed({w_sum, r_q, r_qm1}) >>> 2;
  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_m_ext = signed_mode ? {{2{M[W-1]}}, M} : {2'b00, M};
  assign w_q_ext = signed_mode ? {{2{Q[W-1]}}, Q} : {2'b00, Q};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ITER;
      ITER:    if (w_last) w_next = OUT_LO;
      OUT_LO:  w_next = OUT_HI;
      OUT_HI:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_hi    <= 1'b0;
      r_done      <= 1'b0;
      r_outbus    <= '0;
      r_product   <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != IDLE);
      r_out_valid <= (w_next == OUT_LO) || (w_next == OUT_HI);
      r_out_hi    <= (w_next == OUT_HI);
      r_done      <= (w_next == OUT_HI);
      if (w_next == OUT_LO)
        r_outbus <= w_shift[W:1];
      else if (w_next == OUT_HI)
        r_outbus <= r_product[2*W-1:W];
      else
        r_outbus <= '0;
      if (r_state == ITER && w_last)
        r_product <= w_shift[2*W:1];
    end
  end

  // Bits above 2W of {A, Q} are redundant and simply dropped at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= '0;
            r_q   <= w_q_ext;
            r_m   <= w_m_ext;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
          end
        end
        ITER: begin
          {r_a, r_q, r_qm1} <= w_shift;
          r_cnt             <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_hi    = r_out_hi;
  assign done      = r_done;
  assign outbus    = r_outbus;
  assign product   = r_product;

endmodule
